seg7_scan_mux: RTL and testbench

Time-multiplexed N-digit seven-segment driver; parametrised successor of the single-digit state-to-segment decoder.
- Scans N_DIG common-segment digits, one digit per DIV clocks, and decodes a hex nibble per digit.
- Adds per-digit blanking, blinking, decimal point, polarity selection, and tear-free double-buffered loading.
- Sits between the control FSM / datapath and the board display pins.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_hex_dec.sv | 12 +
 rtl/seg7_scan_mux.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: hex glyph table, dark pattern and
// a counter-width helper used by the scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // seg[6:0] = g..a, bit 0 is segment a
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Counter width for a 0..n-1 range, never below one bit.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to seven-segment decoder.
// Ports: nib (4-bit value in), seg (segments out, bit 0 = a).
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG7_HEX[nib];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered
// digit data, per-digit blank/blink/dp and selectable pin polarity.
// Ports: clk, rst (async high), en, load, digits, dp_in, blank, blink
// in; seg, dp, an (registered pins) and frame_tick out.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIG      = 4,
  parameter int DIV        = 1000,
  parameter int BLINK_DIV  = 64,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [4*N_DIG-1:0] digits,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blank,
  input  logic [N_DIG-1:0]   blink,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [N_DIG-1:0]   an,
  output logic               frame_tick
);

  localparam int PW = cw(DIV);
  localparam int IW = cw(N_DIG);
  localparam int FW = cw(BLINK_DIV);

  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_DIG - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_DIV - 1);

  localparam logic [6:0]       SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [N_DIG-1:0] AN_POL  = {N_DIG{ACTIVE_LOW}};

  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  logic [FW-1:0] fcnt;
  logic          phase;
  logic          bnd_q;

  logic               pend_v;
  logic [4*N_DIG-1:0] dig_p, dig_c;
  logic [N_DIG-1:0]   dp_p, dp_c;
  logic [N_DIG-1:0]   blank_p, blank_c;
  logic [N_DIG-1:0]   blink_p, blink_c;

  logic             slot_end;
  logic             frame_end;
  logic             commit;
  logic             dark;
  logic [3:0]       nib;
  logic [6:0]       hex_seg;
  logic [N_DIG-1:0] an_l;

  assign slot_end  = (pcnt == P_LAST);
  assign frame_end = slot_end && (idx == I_LAST);
  assign commit    = en && frame_end && pend_v;

  assign nib  = 4'(dig_c >> (4 * int'(idx)));
  assign dark = blank_c[idx] | (blink_c[idx] & phase);

  always_comb begin
    an_l      = '0;
    an_l[idx] = 1'b1;
  end

  seg7_hex_dec u_dec (
    .nib (nib),
    .seg (hex_seg)
  );

  // Scan counters: frozen while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt  <= '0;
      idx   <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
      bnd_q <= 1'b0;
    end else if (en) begin
      bnd_q <= frame_end;
      pcnt  <= slot_end ? '0 : pcnt + 1'b1;
      if (slot_end)
        idx <= frame_end ? '0 : idx + 1'b1;
      if (frame_end) begin
        if (fcnt == F_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // Pending/committed buffers. A load coinciding with a commit
  // keeps pend_v set so the new data waits for the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v  <= 1'b0;
      dig_p   <= '0;
      dp_p    <= '0;
      blank_p <= '0;
      blink_p <= '0;
      dig_c   <= '0;
      dp_c    <= '0;
      blank_c <= '0;
      blink_c <= '0;
    end else begin
      if (commit) begin
        dig_c   <= dig_p;
        dp_c    <= dp_p;
        blank_c <= blank_p;
        blink_c <= blink_p;
      end
      if (load) begin
        dig_p   <= digits;
        dp_p    <= dp_in;
        blank_p <= blank;
        blink_p <= blink;
        pend_v  <= 1'b1;
      end else if (commit) begin
        pend_v <= 1'b0;
      end
    end
  end

  // Output registers hold pin-level values; a dark digit keeps its
  // anode so every slot draws the same duty cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF ^ SEG_POL;
      dp         <= ACTIVE_LOW;
      an         <= AN_POL;
      frame_tick <= 1'b0;
    end else begin
      seg        <= ((en && !dark) ? hex_seg : SEG_OFF) ^ SEG_POL;
      dp         <= (en & ~dark & dp_c[idx]) ^ ACTIVE_LOW;
      an         <= (en ? an_l : '0) ^ AN_POL;
      frame_tick <= en & bnd_q;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: scan order, buffering,
// blink/blank, enable freeze, async reset and inverted pins.
module tb_seg7_scan_mux;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  blink = '0;

  logic [6:0] seg, seg_n;
  logic       dp, dp_n;
  logic [3:0] an, an_n;
  logic       frame_tick, frame_tick_n;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .N_DIG(4), .DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .digits(digits), .dp_in(dp_in), .blank(blank), .blink(blink),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  seg7_scan_mux #(
    .N_DIG(4), .DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b1)
  ) u_dut_n (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .digits(digits), .dp_in(dp_in), .blank(blank), .blink(blink),
    .seg(seg_n), .dp(dp_n), .an(an_n), .frame_tick(frame_tick_n)
  );

  // Expected outputs of frame f (frames counted from reset release):
  // 4 digits x 4 clocks, blink phase is off in frames 2-3, 6-7, ...
  task automatic push_frame(input int f, input logic [15:0] data,
                            input logic [3:0] dpv,
                            input logic [3:0] blk,
                            input logic [3:0] bln);
    exp_t       e;
    logic [3:0] nb;
    logic       off;
    for (int d = 0; d < 4; d++) begin
      for (int p = 0; p < 4; p++) begin
        nb   = data[4*d +: 4];
        off  = blk[d] | (bln[d] & (((f / 2) % 2) == 1));
        e.an  = 4'(1 << d);
        e.seg = off ? 7'h00 : hex_tab[nb];
        e.dp  = off ? 1'b0 : dpv[d];
        e.ft  = (d == 0) && (p == 0) && (f > 0);
        sb.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({an, seg, dp, frame_tick} !== 13'h0) begin
      errors++;
      $display("FAIL reset_logical: got %h want 0",
               {an, seg, dp, frame_tick});
    end
    checks++;
    if ({an_n, seg_n, dp_n, frame_tick_n} !== 13'b1111_1111111_1_0) begin
      errors++;
      $display("FAIL reset_pins_inv: got %b want 1111111111110",
               {an_n, seg_n, dp_n, frame_tick_n});
    end
  endtask

  task automatic test_scan();
    exp_t e;
    push_frame(0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    push_frame(1, 16'h1234, 4'b0101, 4'b0000, 4'b0000);
    push_frame(2, 16'h1234, 4'b0101, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; load = 1'b1;
    digits = 16'h1234; dp_in = 4'b0101;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      if (i == 0) load = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++;
        $display("FAIL scan[%0d]: got %h want %h", i,
                 {an, seg, dp, frame_tick}, e);
      end
      checks++;
      if ({an_n, seg_n, dp_n} !== ~{e.an, e.seg, e.dp} ||
          frame_tick_n !== e.ft) begin
        errors++;
        $display("FAIL scan_inv[%0d]: got %b want %b", i,
                 {an_n, seg_n, dp_n, frame_tick_n},
                 {~{e.an, e.seg, e.dp}, e.ft});
      end
    end
  endtask

  task automatic test_double_load();
    exp_t e;
    push_frame(3, 16'h1234, 4'b0101, 4'b0000, 4'b0000);
    push_frame(4, 16'hEF01, 4'b0101, 4'b0000, 4'b0000);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin load = 1'b1; digits = 16'hABCD; end
      if (i == 4) load = 1'b0;
      if (i == 7) begin load = 1'b1; digits = 16'hEF01; end
      if (i == 8) load = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++;
        $display("FAIL dbl_load[%0d]: got %h want %h", i,
                 {an, seg, dp, frame_tick}, e);
      end
    end
  endtask

  task automatic test_blink_blank();
    exp_t e;
    push_frame(5, 16'hEF01, 4'b0101, 4'b0000, 4'b0000);
    for (int f = 6; f < 10; f++)
      push_frame(f, 16'h5678, 4'b0101, 4'b1000, 4'b0010);
    load = 1'b1; digits = 16'h5678;
    blank = 4'b1000; blink = 4'b0010;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (i == 0) load = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++;
        $display("FAIL blink[%0d]: got %h want %h", i,
                 {an, seg, dp, frame_tick}, e);
      end
    end
  endtask

  task automatic test_enable_hold();
    exp_t e;
    push_frame(10, 16'h5678, 4'b0101, 4'b1000, 4'b0010);
    for (int j = 0; j < 10; j++) sb.insert(2, exp_t'(0));
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      if (i == 1) en = 1'b0;
      if (i == 11) en = 1'b1;
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++;
        $display("FAIL en_hold[%0d]: got %h want %h", i,
                 {an, seg, dp, frame_tick}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    push_frame(11, 16'h5678, 4'b0101, 4'b1000, 4'b0010);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin load = 1'b1; digits = 16'h9999; end
      if (i == 1) load = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++;
        $display("FAIL pre_rst[%0d]: got %h want %h", i,
                 {an, seg, dp, frame_tick}, e);
      end
    end
    sb.delete();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({an, seg, dp, frame_tick} !== 13'h0 ||
        {an_n, seg_n, dp_n} !== 12'hFFF) begin
      errors++;
      $display("FAIL async_rst: got %h / %h want 0 / fff",
               {an, seg, dp, frame_tick}, {an_n, seg_n, dp_n});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push_frame(0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++;
        $display("FAIL post_rst[%0d]: got %h want %h", i,
                 {an, seg, dp, frame_tick}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_double_load();
    test_blink_blank();
    test_enable_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
